display_blitter: RTL and testbench
==================================

Name: display_blitter

Overview:
- Write-side engine for the 32x32 colour framebuffer that the VGA display path scans out (byte per cell at BASE_ADDR + y*32 + x, colour index in bits [2:0]).
- Accepts pixel, rectangle-fill and clear commands over a valid/ready handshake.
- Turns each command into a row-major stream of single-byte memory writes, stalled by a bus grant from the CPU/memory arbiter.
- Lets the 6502 side draw with one command instead of many store instructions.

Parameters:
- BASE_ADDR, 16'h0200, byte address of framebuffer cell (0,0)
- GRID_W, 32, framebuffer width in cells (power of two)
- GRID_H, 32, framebuffer height in cells

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=pixel, 1=rect fill, 2=clear screen, 3=reserved (treated as no-op)
- cmd_x  in  5  start column
- cmd_y  in  5  start row
- cmd_w  in  6  rect width in cells, 0..32 (ignored for pixel/clear)
- cmd_h  in  6  rect height in cells, 0..32 (ignored for pixel/clear)
- cmd_color  in  3  colour index
- mem_addr  out  16  write address
- mem_wdata  out  8  write data, {5'b0, colour}
- mem_we  out  1  write request
- mem_grant  in  1  arbiter accepts the write presented this cycle
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; any in-flight command is dropped with no completion pulse.
  - Outputs: mem_we=0, busy=0, done=0, cmd_ready=1, mem_addr=BASE_ADDR, mem_wdata=0.
  - mem_we must fall in the same cycle rst_n asserts; it must not wait for a clock edge.
- States: IDLE, WRITE, FINISH.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on any edge where cmd_valid && cmd_ready.
  - On accept, latch the colour and compute the effective rectangle:
    - pixel: (x, y, 1, 1)
    - clear: (0, 0, GRID_W, GRID_H)
    - rect: (x, y, min(w, GRID_W-x), min(h, GRID_H-y))
    - reserved op: width 0
  - If effective w or h is 0, go to FINISH; otherwise go to WRITE.
- WRITE:
  - cmd_ready=0 and busy=1.
  - mem_we=1 from the first cycle after accept. The first write appears exactly 1 cycle after the accept edge.
  - mem_addr = BASE_ADDR + row*GRID_W + col, computed modulo 2^16.
  - mem_addr, mem_wdata and mem_we stay stable until a cycle with mem_grant=1.
  - On a granted cycle, advance col. At col = x_end, reset col to x_start and advance row.
  - Advance order is row-major: left to right, then top to bottom.
  - When the last cell's write is granted, go to FINISH. mem_we=0 in the next cycle.
  - With mem_grant held high, the command takes w*h consecutive write cycles, with no bubbles between rows.
- FINISH:
  - Lasts exactly one cycle: done=1, busy=1, cmd_ready=0.
  - Then returns to IDLE.
  - Back-to-back commands: a new command can be accepted 1 cycle after FINISH.
- Clipping:
  - Cells outside the grid are never written and consume no cycles.
  - The command still completes normally with done.
- Stability: command inputs are sampled only at accept; changes during WRITE have no effect.
- Arithmetic:
  - Row/col counters are 6 bits, so x_end = x + w - 1 ≤ 31 without overflow.
  - The address product is a shift when GRID_W is a power of two.
- mem_grant while mem_we=0 is ignored.

Test Plan:
- Pixel, grant tied high: op=0, x=3, y=2, colour=5 → one cycle later mem_addr=16'h0243, mem_wdata=8'h05, mem_we=1 for 1 cycle; done pulses 2 cycles after accept.
- Rect with stalls: op=1, x=30, y=0, w=4, h=2, colour=2, grant toggling 1/0 → writes exactly 16'h021E, 021F, 023E, 023F in that order (clipped to 2x2); each address held through grant-low cycles; done once.
- Clear, grant high: op=2, colour=1 → 1024 consecutive writes 16'h0200..16'h05FF, all data 8'h01; busy high for 1025 cycles.
- Zero size: op=1, w=0, h=5 → no mem_we; done 1 cycle after accept; cmd_ready returns the following cycle.
- Reset mid-command: assert rst_n low after 10 writes of a clear → mem_we drops immediately with no clock edge; done never pulses; after release cmd_ready=1 and a new pixel command works.
- Handshake: cmd_valid held high with changing fields during WRITE → no second accept until after FINISH; first command's colour used for all its writes.

Source files
------------

// File: rtl/display_blitter.sv
// display_blitter: turns pixel, rect-fill and clear commands into a row-major stream
// of single-byte framebuffer writes, paced by the arbiter's mem_grant.
module display_blitter #(
    parameter logic [15:0] BASE_ADDR = 16'h0200,
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [5:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic [2:0]  cmd_color,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic        mem_grant,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [6:0] GW = 7'(GRID_W);
    localparam logic [6:0] GH = 7'(GRID_H);

    state_t     state_q, state_d;
    logic [5:0] col_q, col_d;
    logic [5:0] row_q, row_d;
    logic [5:0] x_start_q, x_start_d;
    logic [5:0] x_end_q, x_end_d;
    logic [5:0] y_end_q, y_end_d;
    logic [2:0] color_q, color_d;

    logic [5:0] eff_x, eff_y;
    logic [6:0] eff_w, eff_h;
    logic [6:0] room_w, room_h;

    // Effective (clipped) rectangle of the command currently on the inputs.
    always_comb begin
        room_w = GW - {2'b00, cmd_x};
        room_h = GH - {2'b00, cmd_y};
        eff_x  = {1'b0, cmd_x};
        eff_y  = {1'b0, cmd_y};
        eff_w  = '0;
        eff_h  = '0;
        case (cmd_op)
            2'd0: begin
                eff_w = 7'd1;
                eff_h = 7'd1;
            end
            2'd1: begin
                eff_w = ({1'b0, cmd_w} < room_w) ? {1'b0, cmd_w} : room_w;
                eff_h = ({1'b0, cmd_h} < room_h) ? {1'b0, cmd_h} : room_h;
            end
            2'd2: begin
                eff_x = '0;
                eff_y = '0;
                eff_w = GW;
                eff_h = GH;
            end
            default: begin
                eff_w = '0;
                eff_h = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        x_start_d = x_start_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        color_d   = color_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    color_d   = cmd_color;
                    col_d     = eff_x;
                    row_d     = eff_y;
                    x_start_d = eff_x;
                    x_end_d   = 6'({1'b0, eff_x} + eff_w - 7'd1);
                    y_end_d   = 6'({1'b0, eff_y} + eff_h - 7'd1);
                    if (eff_w == 7'd0 || eff_h == 7'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // The presented write only retires on a granted cycle.
                if (mem_grant) begin
                    if (col_q == x_end_q) begin
                        if (row_q == y_end_q) begin
                            state_d = FINISH;
                        end else begin
                            col_d = x_start_q;
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_start_q <= x_start_d;
            x_end_q   <= x_end_d;
            y_end_q   <= y_end_d;
            color_q   <= color_d;
        end
    end

    // Decoded straight from the async-reset state so mem_we drops the moment rst_n falls.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = {5'b00000, color_q};
    assign mem_addr  = BASE_ADDR + (16'(row_q) * 16'(GRID_W)) + 16'(col_q);

endmodule

// File: tb/tb_display_blitter.sv
// Self-checking bench for display_blitter: directed vector table, reset/handshake
// sequences and randomized commands checked against a cell-list reference model.
module tb_display_blitter;

    localparam int BASE   = 16'h0200;
    localparam int GRID_W = 32;
    localparam int GRID_H = 32;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [5:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [2:0]  cmd_color;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_grant;
    logic        busy;
    logic        done;

    display_blitter #(
        .BASE_ADDR(16'h0200),
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_x(cmd_x),
        .cmd_y(cmd_y),
        .cmd_w(cmd_w),
        .cmd_h(cmd_h),
        .cmd_color(cmd_color),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_grant(mem_grant),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_count = 0;
    int total_count = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int op;
        int x;
        int y;
        int w;
        int h;
        int color;
        int gmode;
        int hold;
        int exp_writes;
        int exp_first;
    } vec_t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: list every grid cell the command covers, in row-major order.
    task automatic build_model(input int op, input int x, input int y, input int w, input int h);
        int x0, y0, ww, hh;
        exp_q.delete();
        x0 = x; y0 = y; ww = 0; hh = 0;
        case (op)
            0: begin ww = 1; hh = 1; end
            1: begin ww = w; hh = h; end
            2: begin x0 = 0; y0 = 0; ww = GRID_W; hh = GRID_H; end
            default: begin ww = 0; hh = 0; end
        endcase
        for (int r = y0; r < y0 + hh; r++) begin
            for (int c = x0; c < x0 + ww; c++) begin
                if (r < GRID_H && c < GRID_W) exp_q.push_back(16'(BASE + r * GRID_W + c));
            end
        end
    endtask

    // gmode: 0 grant high, 1 grant toggling 1/0, 2 random grant.
    task automatic applyStimulus(input int op, input int x, input int y, input int w, input int h,
                                 input int color, input int gmode, input int hold,
                                 output int n_writes, output int first_addr);
        int exp_n, we_cycles, busy_cycles, cyc;
        logic seen_done, prev_we, prev_grant, g, tog;
        logic [15:0] prev_addr, want;
        logic [7:0] prev_data;
        @(negedge clk);
        build_model(op, x, y, w, h);
        exp_n = exp_q.size();
        cmd_op = 2'(op); cmd_x = 5'(x); cmd_y = 5'(y);
        cmd_w = 6'(w); cmd_h = 6'(h); cmd_color = 3'(color);
        cmd_valid = 1'b1;
        mem_grant = 1'b0;
        checkOutput("ready_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (hold == 0) cmd_valid = 1'b0;
        n_writes = 0; we_cycles = 0; busy_cycles = 0; first_addr = -1;
        seen_done = 1'b0; prev_we = 1'b0; prev_grant = 1'b0; tog = 1'b1;
        prev_addr = '0; prev_data = '0;
        checkOutput("first_we_latency", mem_we, (exp_n > 0) ? 1 : 0);
        checkOutput("zero_done_latency", done, (exp_n == 0) ? 1 : 0);
        cyc = 0;
        while (!seen_done && cyc < 5000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            if (hold != 0) begin
                checkOutput("ready_low_busy", cmd_ready, 0);
                cmd_op = 2'($urandom); cmd_x = 5'($urandom); cmd_y = 5'($urandom);
                cmd_w = 6'($urandom); cmd_h = 6'($urandom); cmd_color = 3'($urandom);
            end
            if (prev_we && !prev_grant) begin
                checkOutput("stall_we_held", mem_we, 1);
                checkOutput("stall_addr_held", mem_addr, prev_addr);
                checkOutput("stall_data_held", mem_wdata, prev_data);
            end
            if (mem_we) begin
                we_cycles++;
                case (gmode)
                    0: g = 1'b1;
                    1: begin g = tog; tog = ~tog; end
                    default: g = 1'($urandom_range(0, 1));
                endcase
                if (g) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_write", mem_addr, 16'hFFFF);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("write_addr", mem_addr, want);
                        checkOutput("write_data", mem_wdata, color);
                    end
                    if (n_writes == 0) first_addr = mem_addr;
                    n_writes++;
                end
            end else begin
                g = 1'($urandom_range(0, 1));
            end
            if (done) begin
                seen_done = 1'b1;
                cmd_valid = 1'b0;
                g = 1'b0;
            end
            mem_grant = g;
            prev_we = mem_we; prev_grant = g; prev_addr = mem_addr; prev_data = mem_wdata;
        end
        if (!seen_done) checkOutput("done_timeout", 0, 1);
        checkOutput("writes_remaining", exp_q.size(), 0);
        checkOutput("busy_cycles", busy_cycles, we_cycles + 1);
        if (gmode == 0) checkOutput("no_bubbles", busy_cycles, exp_n + 1);
        @(negedge clk);
        checkOutput("done_single_pulse", done, 0);
        checkOutput("ready_after_finish", cmd_ready, 1);
        checkOutput("we_idle", mem_we, 0);
        mem_grant = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int nw, fa, wrote;
        vecs[0] = '{op:0, x:3,  y:2,  w:0,  h:0,  color:5, gmode:0, hold:0, exp_writes:1,    exp_first:16'h0243};
        vecs[1] = '{op:1, x:30, y:0,  w:4,  h:2,  color:2, gmode:1, hold:0, exp_writes:4,    exp_first:16'h021E};
        vecs[2] = '{op:2, x:9,  y:9,  w:0,  h:0,  color:1, gmode:0, hold:0, exp_writes:1024, exp_first:16'h0200};
        vecs[3] = '{op:1, x:7,  y:4,  w:0,  h:5,  color:3, gmode:0, hold:0, exp_writes:0,    exp_first:-1};
        vecs[4] = '{op:3, x:1,  y:1,  w:3,  h:3,  color:6, gmode:0, hold:0, exp_writes:0,    exp_first:-1};
        vecs[5] = '{op:1, x:31, y:31, w:5,  h:5,  color:7, gmode:2, hold:0, exp_writes:1,    exp_first:16'h05FF};
        vecs[6] = '{op:1, x:4,  y:1,  w:3,  h:2,  color:4, gmode:0, hold:1, exp_writes:6,    exp_first:16'h0224};
        vecs[7] = '{op:1, x:0,  y:30, w:32, h:32, color:0, gmode:2, hold:0, exp_writes:64,   exp_first:16'h05C0};
        vecs[8] = '{op:1, x:10, y:5,  w:6,  h:0,  color:2, gmode:0, hold:0, exp_writes:0,    exp_first:-1};
        vecs[9] = '{op:0, x:31, y:0,  w:9,  h:9,  color:3, gmode:1, hold:0, exp_writes:1,    exp_first:16'h021F};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
        cmd_w = '0; cmd_h = '0; cmd_color = '0; mem_grant = 1'b0;
        #2;
        checkOutput("reset_we", mem_we, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ready", cmd_ready, 1);
        checkOutput("reset_addr", mem_addr, 16'h0200);
        checkOutput("reset_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                          vecs[i].color, vecs[i].gmode, vecs[i].hold, nw, fa);
            checkOutput($sformatf("vec%0d_writes", i), nw, vecs[i].exp_writes);
            if (vecs[i].exp_writes > 0) checkOutput($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first);
        end

        // Reset in the middle of a clear: mem_we must drop without a clock edge.
        @(negedge clk);
        cmd_op = 2'd2; cmd_color = 3'd1; cmd_valid = 1'b1; mem_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wrote = 0;
        repeat (10) begin
            @(posedge clk);
            if (mem_we) wrote++;
        end
        checkOutput("pre_reset_writes", wrote, 10);
        #2;
        checkOutput("pre_reset_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_we", mem_we, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_ready", cmd_ready, 1);
        checkOutput("async_reset_addr", mem_addr, 16'h0200);
        mem_grant = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_done", done, 0);
        checkOutput("post_reset_ready", cmd_ready, 1);
        applyStimulus(0, 12, 7, 0, 0, 6, 0, 0, nw, fa);
        checkOutput("post_reset_pixel_writes", nw, 1);
        checkOutput("post_reset_pixel_addr", fa, 16'h02EC);

        // Randomized commands against the reference model.
        for (int k = 0; k < 25; k++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 32), $urandom_range(0, 32), $urandom_range(0, 7),
                          $urandom_range(0, 2), $urandom_range(0, 1), nw, fa);
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
